wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back stage of the 5-stage LoongArch pipeline, directly downstream of the memory-access stage.
- Holds the MEM→WB pipeline register and a valid/allowin handshake.
- Captures synchronous data-SRAM read data and holds it across stalls.
- Performs load byte/half extraction and sign/zero extension.
- Drives the register-file write port, the WB forwarding bus, the debug trace outputs and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous active-low reset
- ms_to_ws_valid  in  1  MEM has an instruction for WB
- ws_allowin  out  1  WB can accept an instruction this cycle
- ms_pc  in  32  PC of the MEM instruction
- ms_rf_or_mem  in  1  1 = write-back from memory, 0 = from ALU
- ms_load_op  in  3  load type; encodings in package
- ms_alu_result  in  32  ALU result, or load address for loads
- ms_rf_we  in  1  instruction writes a GPR
- ms_rf_waddr  in  5  destination GPR
- data_sram_rdata  in  32  SRAM read data, valid the cycle after the MEM request
- wb_stall  in  1  external hold of WB (trace back-pressure)
- flush  in  1  kill the WB instruction (exception/ertn)
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- ws_fwd_valid  out  1  WB forwarding entry valid
- ws_fwd_waddr  out  5  forwarding destination
- ws_fwd_wdata  out  32  forwarding data
- debug_wb_pc  out  32  trace PC
- debug_wb_rf_we  out  4  trace write strobe
- debug_wb_rf_wnum  out  5  trace register number
- debug_wb_rf_wdata  out  32  trace data
- retire_cnt  out  CNT_W  count of retired instructions

Behaviour:
- Reset (async, resetn=0): ws_valid=0; all pipeline registers 0; hold_valid=0; retire_cnt=0. As a consequence, rf_we=0, ws_fwd_valid=0, debug_wb_rf_we=0, and debug_wb_pc=0.
- Handshake:
  - ws_ready_go = !wb_stall.
  - ws_allowin = !ws_valid | ws_ready_go.
  - On posedge: if flush, ws_valid←0; else if ws_allowin, ws_valid←ms_to_ws_valid.
  - Payload registers load on ms_to_ws_valid & ws_allowin.
  - flush has priority over a simultaneous accept, and the accepted instruction is dropped.
- Read-data hold:
  - eff_rdata = hold_valid ? hold_rdata : data_sram_rdata.
  - If ws_valid & !ws_ready_go & !hold_valid: hold_rdata←data_sram_rdata, hold_valid←1.
  - hold_valid clears when ws_ready_go=1 or on flush.
  - This guarantees the first-cycle SRAM data is used even under a multi-cycle stall.
- Load extraction uses addr[1:0] = ws_alu_result[1:0]:
  - LD_W: the whole word.
  - LD_B/LD_BU: byte at addr[1:0], sign- or zero-extended.
  - LD_H/LD_HU: halfword at addr[1] (addr[0] ignored; alignment is an EXE exception), sign- or zero-extended.
  - Undefined encodings behave as LD_W.
- final_data = ws_rf_or_mem ? extracted : ws_alu_result.
- Commit:
  - commit = ws_valid & ws_ready_go & !flush.
  - rf_we = commit & ws_rf_we.
  - rf_waddr = ws_rf_waddr; rf_wdata = final_data.
  - The write is combinational in the commit cycle (1-cycle WB latency after accept).
  - A write to r0 is passed through; the regfile ignores it.
- Forwarding:
  - ws_fwd_valid = ws_valid & ws_rf_we & (ws_rf_waddr≠0).
  - This is asserted even while stalled, so ID interlocks correctly.
  - ws_fwd_waddr/ws_fwd_wdata mirror rf_waddr/final_data.
- Debug:
  - debug_wb_pc = ws_pc.
  - debug_wb_rf_we = {4{rf_we}}.
  - debug_wb_rf_wnum = rf_waddr; debug_wb_rf_wdata = rf_wdata.
- Counter: retire_cnt increments by 1 on each commit and wraps modulo 2^CNT_W with no saturation.
- Reset mid-stall clears the hold and the valid bit immediately (asynchronous).

Decomposition:
- Shared package (cpu_pkg):
  - LOAD_OP_W=3.
  - LD_W=0, LD_B=1, LD_BU=2, LD_H=3, LD_HU=4.
  - MEM→WB bus width constant.
- One sub-module: load_align. It is combinational: rdata, addr_lo[1:0] and load_op in, 32-bit extended data out. It is reused by future uncached-load paths.

Test Plan:
- ALU write-back: accept pc=0x1c000000, rf_or_mem=0, alu=0x12345678, waddr=5. Next cycle: rf_we=1, rf_waddr=5, rf_wdata=0x12345678, debug_wb_rf_we=4'hF, retire_cnt=1.
- Byte loads: rdata=0x80FF7F01 with addr_lo=3. LD_B gives 0xFFFFFF80. LD_BU gives 0x00000080. With addr_lo=1, LD_B gives 0xFFFFFF80 for 0x00008000.
- Half loads: rdata=0x8001ABCD. LD_H at addr_lo=2 gives 0xFFFF8001. LD_HU at addr_lo=0 gives 0x0000ABCD.
- Stall hold: issue LD_W, then hold wb_stall=1 for 3 cycles while data_sram_rdata changes 0xAAAA0000→0xDEADBEEF. After release, rf_wdata=0xAAAA0000. ws_allowin=0 and ws_fwd_valid=1 during the stall, with exactly one write.
- Flush: assert flush in the commit cycle. Expect rf_we=0, no retire_cnt increment, and ws_valid=0 next cycle. If flush coincides with an accept, the incoming instruction is never written.
- Reset/r0/wrap: drop resetn mid-stall and all outputs go to 0 immediately. A write to r0 gives ws_fwd_valid=0 while rf_we=1. Preload CNT_W=4 to 15; one commit gives retire_cnt=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline types: load-op encodings and the MEM->WB payload layout
package cpu_pkg;

  localparam int LOAD_OP_W = 3;

  typedef enum logic [LOAD_OP_W-1:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } load_op_e;

  typedef struct packed {
    logic [31:0]          pc;
    logic                 rf_or_mem;
    logic [LOAD_OP_W-1:0] load_op;
    logic [31:0]          alu_result;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
  } ms_to_ws_t;

  localparam int MS_TO_WS_BUS_W = $bits(ms_to_ws_t);

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational load byte/half selection with sign/zero extension
// Halfword select ignores addr_lo[0]; misalignment is trapped upstream.
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0]          rdata_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [LOAD_OP_W-1:0] load_op_i,
  output logic [31:0]          data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o   = rdata_i;
    case (load_op_i)
      LD_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data_o = {24'd0, byte_sel};
      LD_H:    data_o = {{16{half_sel[15]}}, half_sel};
      LD_HU:   data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: MEM->WB register, SRAM data hold, load extraction, regfile/forward/trace
module wb_stage
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ms_to_ws_valid,
  output logic                 ws_allowin,
  input  logic [31:0]          ms_pc,
  input  logic                 ms_rf_or_mem,
  input  logic [LOAD_OP_W-1:0] ms_load_op,
  input  logic [31:0]          ms_alu_result,
  input  logic                 ms_rf_we,
  input  logic [4:0]           ms_rf_waddr,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 wb_stall,
  input  logic                 flush,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 ws_fwd_valid,
  output logic [4:0]           ws_fwd_waddr,
  output logic [31:0]          ws_fwd_wdata,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata,
  output logic [CNT_W-1:0]     retire_cnt
);

  logic                      ws_valid_q, ws_valid_d;
  ms_to_ws_t                 ws_q, ws_d;
  logic                      hold_valid_q, hold_valid_d;
  logic [31:0]               hold_rdata_q, hold_rdata_d;
  logic [CNT_W-1:0]          retire_cnt_q, retire_cnt_d;
  logic [MS_TO_WS_BUS_W-1:0] ms_to_ws_bus;
  logic                      ws_ready_go;
  logic                      commit;
  logic [31:0]               eff_rdata;
  logic [31:0]               load_data;
  logic [31:0]               final_data;

  assign ms_to_ws_bus = {ms_pc, ms_rf_or_mem, ms_load_op, ms_alu_result, ms_rf_we, ms_rf_waddr};

  assign ws_ready_go = !wb_stall;
  assign ws_allowin  = !ws_valid_q | ws_ready_go;
  assign commit      = ws_valid_q & ws_ready_go & !flush;

  // SRAM data is only valid on the first WB cycle, so a stall must latch it then.
  assign eff_rdata = hold_valid_q ? hold_rdata_q : data_sram_rdata;

  always_comb begin
    ws_valid_d   = ws_valid_q;
    ws_d         = ws_q;
    hold_valid_d = hold_valid_q;
    hold_rdata_d = hold_rdata_q;
    retire_cnt_d = retire_cnt_q;

    if (flush) begin
      ws_valid_d = 1'b0;
    end else if (ws_allowin) begin
      ws_valid_d = ms_to_ws_valid;
    end

    if (ms_to_ws_valid & ws_allowin) begin
      ws_d = ms_to_ws_bus;
    end

    if (flush | ws_ready_go) begin
      hold_valid_d = 1'b0;
    end else if (ws_valid_q & !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_rdata_d = data_sram_rdata;
    end

    if (commit) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q   <= 1'b0;
      ws_q         <= '0;
      hold_valid_q <= 1'b0;
      hold_rdata_q <= 32'd0;
      retire_cnt_q <= '0;
    end else begin
      ws_valid_q   <= ws_valid_d;
      ws_q         <= ws_d;
      hold_valid_q <= hold_valid_d;
      hold_rdata_q <= hold_rdata_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  load_align u_load_align (
    .rdata_i   (eff_rdata),
    .addr_lo_i (ws_q.alu_result[1:0]),
    .load_op_i (ws_q.load_op),
    .data_o    (load_data)
  );

  assign final_data = ws_q.rf_or_mem ? load_data : ws_q.alu_result;

  assign rf_we    = commit & ws_q.rf_we;
  assign rf_waddr = ws_q.rf_waddr;
  assign rf_wdata = final_data;

  // Forwarding stays asserted while stalled so ID keeps interlocking on this register.
  assign ws_fwd_valid = ws_valid_q & ws_q.rf_we & (ws_q.rf_waddr != 5'd0);
  assign ws_fwd_waddr = ws_q.rf_waddr;
  assign ws_fwd_wdata = final_data;

  assign debug_wb_pc       = ws_q.pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
  assign retire_cnt        = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage with a slot-level reference model
module tb_wb_stage;

  localparam int CNT_W = 4;

  logic             clk;
  logic             resetn;
  logic             ms_to_ws_valid;
  logic             ws_allowin;
  logic [31:0]      ms_pc;
  logic             ms_rf_or_mem;
  logic [2:0]       ms_load_op;
  logic [31:0]      ms_alu_result;
  logic             ms_rf_we;
  logic [4:0]       ms_rf_waddr;
  logic [31:0]      data_sram_rdata;
  logic             wb_stall;
  logic             flush;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             ws_fwd_valid;
  logic [4:0]       ws_fwd_waddr;
  logic [31:0]      ws_fwd_wdata;
  logic [31:0]      debug_wb_pc;
  logic [3:0]       debug_wb_rf_we;
  logic [4:0]       debug_wb_rf_wnum;
  logic [31:0]      debug_wb_rf_wdata;
  logic [CNT_W-1:0] retire_cnt;

  wb_stage #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ws_allowin        (ws_allowin),
    .ms_pc             (ms_pc),
    .ms_rf_or_mem      (ms_rf_or_mem),
    .ms_load_op        (ms_load_op),
    .ms_alu_result     (ms_alu_result),
    .ms_rf_we          (ms_rf_we),
    .ms_rf_waddr       (ms_rf_waddr),
    .data_sram_rdata   (data_sram_rdata),
    .wb_stall          (wb_stall),
    .flush             (flush),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_fwd_valid      (ws_fwd_valid),
    .ws_fwd_waddr      (ws_fwd_waddr),
    .ws_fwd_wdata      (ws_fwd_wdata),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .retire_cnt        (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          allowin;
    bit          fwd_v;
    logic [4:0]  fwd_wa;
    logic [31:0] fwd_wd;
    bit          we;
    logic [31:0] pc;
    logic [3:0]  cnt;
  } cyc_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  cyc_t cyc_q[$];
  wr_t  wr_q[$];

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: the one instruction sitting in WB, with the data it saw on its first cycle.
  bit          s_v, s_first, s_rom, s_we;
  logic [31:0] s_pc, s_alu, s_data;
  logic [2:0]  s_op;
  logic [4:0]  s_wa;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] d, input int a, input logic [2:0] op);
    int unsigned b, h;
    b = (d >> (8 * a)) & 32'hFF;
    h = (d >> (16 * (a / 2))) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 128) ? b - 256 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return h;
      default: return d;
    endcase
  endfunction

  task automatic model_reset();
    s_v = 0; s_first = 0; s_rom = 0; s_we = 0;
    s_pc = 0; s_alu = 0; s_data = 0; s_op = 0; s_wa = 0;
    m_cnt = 0;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit rom, input logic [2:0] op,
                       input logic [31:0] alu, input bit we, input logic [4:0] wa,
                       input logic [31:0] rd, input bit st, input bit fl);
    cyc_t        c;
    wr_t         w;
    bit          commit, allow;
    logic [31:0] fin;
    ms_to_ws_valid  = v;
    ms_pc           = pc;
    ms_rf_or_mem    = rom;
    ms_load_op      = op;
    ms_alu_result   = alu;
    ms_rf_we        = we;
    ms_rf_waddr     = wa;
    data_sram_rdata = rd;
    wb_stall        = st;
    flush           = fl;

    if (s_v && s_first) begin
      s_data  = rd;
      s_first = 0;
    end
    fin    = s_rom ? ref_load(s_data, int'(s_alu[1:0]), s_op) : s_alu;
    commit = s_v && !st && !fl;
    allow  = !s_v || !st;

    c.allowin = allow;
    c.fwd_v   = s_v && s_we && (s_wa != 0);
    c.fwd_wa  = s_wa;
    c.fwd_wd  = fin;
    c.we      = commit && s_we;
    c.pc      = s_pc;
    c.cnt     = 4'(m_cnt);
    cyc_q.push_back(c);

    if (commit) begin
      m_cnt = (m_cnt + 1) % 16;
      if (s_we) begin
        w.pc = s_pc; w.wa = s_wa; w.wd = fin;
        wr_q.push_back(w);
      end
    end

    if (fl) s_v = 0;
    else if (allow) s_v = v;
    if (v && allow) begin
      s_pc = pc; s_rom = rom; s_op = op; s_alu = alu; s_we = we; s_wa = wa;
      s_first = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] rd, input bit st);
    drive(0, 32'h0, 0, 3'd0, 32'h0, 0, 5'd0, rd, st, 0);
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (cyc_q.size() > 0) begin
        cyc_t c;
        c = cyc_q.pop_front();
        chk("ws_allowin", 32'(ws_allowin), 32'(c.allowin));
        chk("ws_fwd_valid", 32'(ws_fwd_valid), 32'(c.fwd_v));
        if (c.fwd_v) begin
          chk("ws_fwd_waddr", 32'(ws_fwd_waddr), 32'(c.fwd_wa));
          chk("ws_fwd_wdata", ws_fwd_wdata, c.fwd_wd);
        end
        chk("rf_we", 32'(rf_we), 32'(c.we));
        chk("debug_wb_rf_we", 32'(debug_wb_rf_we), c.we ? 32'hF : 32'h0);
        chk("debug_wb_pc", debug_wb_pc, c.pc);
        chk("retire_cnt", 32'(retire_cnt), 32'(c.cnt));
      end
      if (rf_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 32'(rf_waddr), 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_pc", debug_wb_pc, w.pc);
          chk("wr_waddr", 32'(rf_waddr), 32'(w.wa));
          chk("wr_wdata", rf_wdata, w.wd);
          chk("trace_wnum", 32'(debug_wb_rf_wnum), 32'(w.wa));
          chk("trace_wdata", debug_wb_rf_wdata, w.wd);
        end
      end
    end
  end

  initial begin
    int guard;
    resetn = 0;
    model_reset();
    ms_to_ws_valid = 0; ms_pc = 0; ms_rf_or_mem = 0; ms_load_op = 0; ms_alu_result = 0;
    ms_rf_we = 0; ms_rf_waddr = 0; data_sram_rdata = 0; wb_stall = 0; flush = 0;
    #3;
    chk("rst_rf_we", 32'(rf_we), 32'h0);
    chk("rst_fwd_valid", 32'(ws_fwd_valid), 32'h0);
    chk("rst_dbg_we", 32'(debug_wb_rf_we), 32'h0);
    chk("rst_dbg_pc", debug_wb_pc, 32'h0);
    chk("rst_retire_cnt", 32'(retire_cnt), 32'h0);
    chk("rst_allowin", 32'(ws_allowin), 32'h1);
    step();
    resetn = 1;

    // ALU write-back
    drive(1, 32'h1c000000, 0, 3'd0, 32'h12345678, 1, 5'd5, 32'h0, 0, 0); step();
    idle(32'h0, 0);
    #2;
    chk("alu_rf_we", 32'(rf_we), 32'h1);
    chk("alu_rf_waddr", 32'(rf_waddr), 32'h5);
    chk("alu_rf_wdata", rf_wdata, 32'h12345678);
    chk("alu_dbg_we", 32'(debug_wb_rf_we), 32'hF);
    step();
    #2 chk("alu_retire_cnt", 32'(retire_cnt), 32'h1);

    // byte and half loads, back to back
    drive(1, 32'h1c000010, 1, 3'd1, 32'h00000103, 1, 5'd10, 32'h0, 0, 0); step();
    drive(1, 32'h1c000014, 1, 3'd2, 32'h00000203, 1, 5'd11, 32'h80FF7F01, 0, 0);
    #2 chk("ld_b_a3", rf_wdata, 32'hFFFFFF80); step();
    drive(1, 32'h1c000018, 1, 3'd1, 32'h00000301, 1, 5'd12, 32'h80FF7F01, 0, 0);
    #2 chk("ld_bu_a3", rf_wdata, 32'h00000080); step();
    drive(1, 32'h1c00001c, 1, 3'd3, 32'h00000402, 1, 5'd13, 32'h00008000, 0, 0);
    #2 chk("ld_b_a1", rf_wdata, 32'hFFFFFF80); step();
    drive(1, 32'h1c000020, 1, 3'd4, 32'h00000500, 1, 5'd14, 32'h8001ABCD, 0, 0);
    #2 chk("ld_h_a2", rf_wdata, 32'hFFFF8001); step();
    idle(32'h8001ABCD, 0);
    #2 chk("ld_hu_a0", rf_wdata, 32'h0000ABCD); step();

    // stall hold of first-cycle SRAM data
    drive(1, 32'h1c000030, 1, 3'd0, 32'h00000600, 1, 5'd7, 32'h0, 0, 0); step();
    idle(32'hAAAA0000, 1);
    #2;
    chk("stall_allowin", 32'(ws_allowin), 32'h0);
    chk("stall_fwd_valid", 32'(ws_fwd_valid), 32'h1);
    chk("stall_no_write", 32'(rf_we), 32'h0);
    step();
    idle(32'hDEADBEEF, 1); step();
    idle(32'hDEADBEEF, 1); step();
    idle(32'hDEADBEEF, 0);
    #2;
    chk("hold_rf_we", 32'(rf_we), 32'h1);
    chk("hold_rf_wdata", rf_wdata, 32'hAAAA0000);
    step();

    // flush in commit cycle, coinciding with an accept
    drive(1, 32'h1c000040, 0, 3'd0, 32'h11111111, 1, 5'd3, 32'h0, 0, 0); step();
    drive(1, 32'h1c000044, 0, 3'd0, 32'h22222222, 1, 5'd4, 32'h0, 0, 1);
    #2 chk("flush_rf_we", 32'(rf_we), 32'h0); step();
    idle(32'h0, 1);
    #2;
    chk("flush_valid_clear", 32'(ws_allowin), 32'h1);
    chk("flush_dropped_fwd", 32'(ws_fwd_valid), 32'h0);
    chk("flush_dropped_we", 32'(rf_we), 32'h0);
    chk("flush_cnt", 32'(retire_cnt), 32'(m_cnt));
    step();

    // write to r0
    drive(1, 32'h1c000050, 0, 3'd0, 32'hCAFE0000, 1, 5'd0, 32'h0, 0, 0); step();
    idle(32'h0, 0);
    #2;
    chk("r0_rf_we", 32'(rf_we), 32'h1);
    chk("r0_fwd_valid", 32'(ws_fwd_valid), 32'h0);
    step();

    // counter wrap from 15
    guard = 0;
    while (m_cnt != 15 && guard < 40) begin
      drive(1, 32'h1c000060, 0, 3'd0, 32'h00000123, 1, 5'd1, 32'h0, 0, 0); step();
      guard++;
    end
    idle(32'h0, 0); step();
    #2 chk("cnt_wrap", 32'(retire_cnt), 32'h0);

    // asynchronous reset in the middle of a stall
    drive(1, 32'h1c000070, 1, 3'd0, 32'h00000700, 1, 5'd9, 32'h0, 0, 0); step();
    idle(32'h5555AAAA, 1); step();
    idle(32'h5555AAAA, 1);
    #2 resetn = 0;
    #1;
    chk("arst_rf_we", 32'(rf_we), 32'h0);
    chk("arst_fwd_valid", 32'(ws_fwd_valid), 32'h0);
    chk("arst_dbg_we", 32'(debug_wb_rf_we), 32'h0);
    chk("arst_dbg_pc", debug_wb_pc, 32'h0);
    chk("arst_rf_wdata", rf_wdata, 32'h0);
    chk("arst_retire_cnt", 32'(retire_cnt), 32'h0);
    chk("arst_allowin", 32'(ws_allowin), 32'h1);
    cyc_q.delete();
    wr_q.delete();
    model_reset();
    step();
    resetn = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, $urandom, $urandom % 2, 3'($urandom % 8), $urandom,
            $urandom % 2, 5'($urandom % 32), $urandom, ($urandom % 4) == 0, ($urandom % 16) == 0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      idle(32'h0, 0); step();
    end
    chk("writes_outstanding", 32'(wr_q.size()), 32'h0);
    chk("final_retire_cnt", 32'(retire_cnt), 32'(m_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
